// File: rtl/mult_div_pkg.sv
// Shared encodings and helpers for the sequential multiply/divide unit.
package mult_div_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // Widest operand abs_val can handle; callers zero-extend into this width.
  localparam int unsigned MD_MAX_W = 64;

  // Magnitude of the w-bit two's complement value held in v[w-1:0].
  // The value is left-justified so the sign lands in the MSB, negated there,
  // then shifted back; the most negative value returns 2^(w-1) unsigned.
  function automatic logic [MD_MAX_W-1:0] abs_val(input logic [MD_MAX_W-1:0] v,
                                                  input int unsigned         w);
    logic [MD_MAX_W-1:0] t;
    t = v << (MD_MAX_W - w);
    if (t[MD_MAX_W-1]) t = ~t + MD_MAX_W'(1);
    return t >> (MD_MAX_W - w);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Sequential MULT/MULTU/DIV/DIVU with HI/LO result registers.
// One iteration per clock, WIDTH+2 cycles start-to-done; start ignored while busy.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e            state_q, state_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 div0_q, div0_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 sgn_op, div_op;
  logic [WIDTH-1:0]     a_mag, b_mag, a_in, b_in;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       rem_sh, rem_sub;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign sgn_op = ~op[0];
  assign div_op = op[1];
  assign a_mag  = WIDTH'(abs_val(MD_MAX_W'(src_a), WIDTH));
  assign b_mag  = WIDTH'(abs_val(MD_MAX_W'(src_b), WIDTH));
  assign a_in   = sgn_op ? a_mag : src_a;
  assign b_in   = sgn_op ? b_mag : src_b;

  // Multiply: acc holds {partial product, remaining multiplier bits}.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};

  // Divide: acc[WIDTH-1:0] shifts dividend bits out and quotient bits in.
  assign rem_sh  = {rem_q, acc_q[WIDTH-1]};
  assign rem_sub = rem_sh - {1'b0, opnd_q};

  assign prod_fix = neg_res_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
  assign quo_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    opnd_d    = opnd_q;
    rem_d     = rem_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_div_d  = div_op;
          neg_res_d = sgn_op & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          neg_rem_d = sgn_op & src_a[WIDTH-1];
          opnd_d    = div_op ? b_in : a_in;
          acc_d     = {{WIDTH{1'b0}}, (div_op ? a_in : b_in)};
          rem_d     = '0;
          busy_d    = 1'b1;
          if (div_op && (src_b == '0)) begin
            // No iterations: report the fault and leave hi/lo untouched.
            state_d = ST_DONE;
            done_d  = 1'b1;
            div0_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
            cnt_d   = CNT_W'(WIDTH - 1);
          end
        end
      end
      ST_RUN: begin
        if (is_div_q) begin
          rem_d              = rem_sub[WIDTH] ? rem_sh[WIDTH-1:0] : rem_sub[WIDTH-1:0];
          acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], ~rem_sub[WIDTH]};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b0;
        div0_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= '0;
      rem_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      opnd_q    <= opnd_d;
      rem_q     <= rem_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised scoreboard bench for mult_div_unit (WIDTH=32) against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int W      = 32;
  localparam int PERIOD = 10;

  logic          clock;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  src_a, src_b;
  logic          busy, done, div0;
  logic [W-1:0]  hi, lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .done  (done),
    .div0  (div0),
    .hi    (hi),
    .lo    (lo)
  );

  initial clock = 1'b0;
  always #(PERIOD/2) clock = ~clock;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
    int           lat;
    time          t0;
  } exp_t;

  exp_t          sb_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            done_cnt = 0;
  logic [W-1:0]  m_hi = '0, m_lo = '0;
  logic          m_z;
  logic [W-1:0]  spec_v[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic; SV '/' and '%' already truncate toward zero.
  task automatic model(input logic [1:0] mop, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] sa, sb, sp, sq, sr;
    logic        [63:0] up;
    sa = $signed(a);
    sb = $signed(b);
    m_z = 1'b0;
    case (mop)
      2'b00: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; end
      2'b01: begin up = {32'b0, a} * {32'b0, b}; m_hi = up[63:32]; m_lo = up[31:0]; end
      2'b10: begin
        if (b == 0) m_z = 1'b1;
        else begin sq = sa / sb; sr = sa % sb; m_lo = sq[31:0]; m_hi = sr[31:0]; end
      end
      default: begin
        if (b == 0) m_z = 1'b1;
        else begin m_lo = a / b; m_hi = a % b; end
      end
    endcase
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (reset && done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("div0", div0, e.div0);
        chk("latency", ($time - e.t0) / PERIOD, e.lat);
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int intf_cyc, input bit pulse_done, input int rst_cyc);
    exp_t e;
    int   c;
    int   d0;
    bit   got;
    bit   busy_ok;
    @(negedge clock);
    op = o; src_a = a; src_b = b; start = 1'b1;
    if (rst_cyc == 0) begin
      model(o, a, b);
      e.hi = m_hi; e.lo = m_lo; e.div0 = m_z;
      e.lat = m_z ? 1 : W + 2;
      e.t0 = $time;
      sb_q.push_back(e);
    end
    @(negedge clock);
    start = 1'b0;
    op = 2'($urandom); src_a = $urandom; src_b = $urandom;
    c = 1; got = 1'b0; busy_ok = 1'b1;
    while (!got && c <= 60) begin
      if (c == rst_cyc) begin
        reset = 1'b0;
        #1;
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_flags", {busy, done, div0}, 64'd0);
        m_hi = '0; m_lo = '0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        d0 = done_cnt;
        repeat (W + 10) @(negedge clock);
        chk("no_done_after_rst", done_cnt - d0, 64'd0);
        return;
      end
      if (start) start = 1'b0;
      if (c == intf_cyc) begin
        start = 1'b1; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
      end
      if (done) got = 1'b1;
      else begin
        if (!busy) busy_ok = 1'b0;
        @(negedge clock);
        c++;
      end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: done not seen after %0d cycles, required within %0d", c - 1, W + 2);
    end
    chk("busy_held", {busy_ok, busy}, 64'd3);
    if (pulse_done) begin
      start = 1'b1; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
    end
    @(negedge clock);
    start = 1'b0;
    chk("idle_after", {busy, done, div0}, 64'd0);
  endtask

  initial begin : watchdog
    #(PERIOD * 60000);
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    logic [1:0] ro;
    logic [W-1:0] ra, rb;
    reset = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clock);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_flags", {busy, done, div0}, 64'd0);
    reset = 1'b1;

    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 0, 0, 0);
    chk("tp_mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    chk("tp_multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    chk("tp_mult_m1", {hi, lo}, 64'h0000_0000_0000_0001);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, 0);
    chk("tp_div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b11, 32'h0000_0007, 32'h0000_0002, 0, 0, 0);
    chk("tp_divu", {hi, lo}, 64'h0000_0001_0000_0003);
    run_op(2'b11, 32'h5678_1234, 32'h0001_0000, 0, 0, 0);
    chk("tp_prior", {hi, lo}, 64'h0000_1234_0000_5678);
    run_op(2'b10, 32'h0000_0005, 32'h0000_0000, 0, 1, 0);
    chk("tp_div0_hold", {hi, lo}, 64'h0000_1234_0000_5678);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 0, 0);
    chk("tp_div_min", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0, 0);
    chk("tp_mult_min", {hi, lo}, 64'h4000_0000_0000_0000);
    run_op(2'b11, 32'h0000_0003, 32'h0000_0009, 0, 0, 0);
    chk("tp_divu_small", {hi, lo}, 64'h0000_0003_0000_0000);
    run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 10);
    run_op(2'b01, 32'h0000_0003, 32'h0000_0005, 0, 0, 0);
    chk("tp_after_rst", {hi, lo}, 64'h0000_0000_0000_000F);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = ($urandom_range(0, 7) == 0) ? spec_v[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? spec_v[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      run_op(ro, ra, rb,
             ($urandom_range(0, 3) == 0) ? $urandom_range(2, W) : 0,
             $urandom_range(0, 3) == 0, 0);
    end

    repeat (3) @(negedge clock);
    chk("sb_empty", sb_q.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
